// File: rtl/novelty_pkg.sv
// Shared types and constants for the novelty accelerator report path.
// Holds the record layout, frame constants, FSM encoding and the frame byte mux.
package novelty_pkg;
  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam int FRAME_LEN = 7;
  localparam int ADDR_W    = 4;
  localparam int ENERGY_W  = 16;
  localparam int WEIGHT_W  = 8;

  typedef enum logic [2:0] {IDLE, LOAD, START, DATA, STOP} tx_state_t;

  typedef struct packed {
    logic                novel;
    logic [ADDR_W-1:0]   addr;
    logic [ENERGY_W-1:0] energy;
    logic [WEIGHT_W-1:0] weight;
  } rec_t;

  localparam int REC_W = $bits(rec_t);

  // Byte idx of the frame for record r; the last byte is the XOR of bytes 1..5.
  function automatic logic [7:0] frame_byte(input rec_t r, input logic [7:0] seq,
                                            input logic [2:0] idx);
    logic [7:0] hdr;
    logic [7:0] res;
    hdr = {r.novel, 3'b000, r.addr};
    case (idx)
      3'd0:    res = SYNC_BYTE;
      3'd1:    res = hdr;
      3'd2:    res = r.energy[15:8];
      3'd3:    res = r.energy[7:0];
      3'd4:    res = r.weight;
      3'd5:    res = seq;
      default: res = hdr ^ r.energy[15:8] ^ r.energy[7:0] ^ r.weight ^ seq;
    endcase
    return res;
  endfunction
endpackage

// File: rtl/report_fifo.sv
// Synchronous record FIFO with full/empty flags; push and pop may share a cycle.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module report_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rdata   = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end
endmodule

// File: rtl/novelty_report_tx.sv
// Host-bound return path: buffers inference results and sends each as a
// 7-byte framed packet (sync, header, energy, weight, seq, checksum) over 8N1 UART.
module novelty_report_tx
  import novelty_pkg::*;
#(
  parameter int CLK_FREQ   = 27000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                rec_valid,
  output logic                rec_ready,
  input  logic [ADDR_W-1:0]   rec_addr,
  input  logic [ENERGY_W-1:0] rec_energy,
  input  logic [WEIGHT_W-1:0] rec_weight,
  input  logic                rec_novel,
  output logic                tx,
  output logic                busy
);
  localparam int WAIT = CLK_FREQ / BAUD;
  localparam int TW   = (WAIT > 1) ? $clog2(WAIT) : 1;

  tx_state_t       state;
  logic [TW-1:0]   timer;
  logic [2:0]      bit_idx;
  logic [2:0]      byte_idx;
  logic [7:0]      seq;
  rec_t            frame;
  rec_t            head;
  rec_t            in_rec;
  logic            full, empty, push, pop, bit_end;
  logic [7:0]      cur_byte;

  assign in_rec    = '{novel: rec_novel, addr: rec_addr, energy: rec_energy, weight: rec_weight};
  assign rec_ready = ~full;
  assign push      = rec_valid & ~full;
  assign pop       = (state == LOAD);
  assign busy      = (state != IDLE) || !empty;
  assign bit_end   = (timer == TW'(WAIT - 1));
  assign cur_byte  = frame_byte(frame, seq, byte_idx);

  report_fifo #(.WIDTH(REC_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata (in_rec),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  // tx is registered and set on each state transition, so every line bit
  // lasts exactly WAIT cycles from the edge that entered its state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      tx       <= 1'b1;
      timer    <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
      seq      <= '0;
      frame    <= '0;
    end else begin
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (!empty) state <= LOAD;
        end
        LOAD: begin
          frame    <= head;
          byte_idx <= '0;
          bit_idx  <= '0;
          timer    <= '0;
          tx       <= 1'b0;
          state    <= START;
        end
        START: begin
          if (bit_end) begin
            timer   <= '0;
            bit_idx <= '0;
            tx      <= cur_byte[0];
            state   <= DATA;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        DATA: begin
          if (bit_end) begin
            timer <= '0;
            if (bit_idx == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= cur_byte[bit_idx + 3'd1];
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
        STOP: begin
          if (bit_end) begin
            timer <= '0;
            if (byte_idx != 3'(FRAME_LEN - 1)) begin
              byte_idx <= byte_idx + 3'd1;
              tx       <= 1'b0;
              state    <= START;
            end else begin
              // Frame complete: next frame follows directly if a record is waiting.
              seq   <= seq + 8'd1;
              state <= empty ? IDLE : LOAD;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
